// File: rtl/ecg_frame_fifo.sv
// ecg_frame_fifo
//   Multi-channel frame ring buffer between the ADC sample producer and the SPI
//   consumer. NCH samples per conversion form one frame. Only complete frames
//   are committed to the simple dual-port RAM, which holds up to DEPTH frames.
//   Frames are streamed out one word at a time on request.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   frm_start             new conversion frame begins
//   in_valid, in_data     sample strobe and value, channel 0 first
//   rd_req                request the oldest stored frame
//   rd_valid, rd_ready    output word handshake
//   rd_data, rd_ch        output sample and its channel index
//   rd_last               rd_data is the last channel of the frame
//   wm_level, irq         watermark (frames) and registered frames>=wm_level
//   frames                committed frames currently stored
//   drop_cnt              frames dropped because the buffer was full (saturating)
//   err_short, err_extra  sticky framing errors
//   clr_err               clears drop_cnt and the error flags
module ecg_frame_fifo #(
    parameter  int NCH   = 8,
    parameter  int SW    = 24,
    parameter  int DEPTH = 64,
    parameter  int CW    = 8,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            frm_start,
    input  logic            in_valid,
    input  logic [SW-1:0]   in_data,
    input  logic            rd_req,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [SW-1:0]   rd_data,
    output logic [CHW-1:0]  rd_ch,
    output logic            rd_last,
    input  logic [CNTW-1:0] wm_level,
    output logic [CNTW-1:0] frames,
    output logic            irq,
    output logic [CW-1:0]   drop_cnt,
    output logic            err_short,
    output logic            err_extra,
    input  logic            clr_err
);

    localparam int FW = $clog2(DEPTH);
    localparam int AW = $clog2(DEPTH * NCH);

    // W_IDLE: no frame seen since reset, W_FILL: collecting, W_DROP: frame
    // rejected because full, W_DONE: frame committed, waiting for frm_start.
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP, W_DONE} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_PRESENT} rd_state_t;

    logic [SW-1:0]  mem [DEPTH*NCH];
    logic [SW-1:0]  mem_q;

    wr_state_t      wr_state;
    logic [CHW-1:0] ch_cnt;
    logic [FW-1:0]  wr_frame;
    rd_state_t      rd_state;
    logic [CHW-1:0] rd_idx;
    logic [FW-1:0]  rd_frame;

    logic           full, drop, wr_en, commit, pop, set_short, set_extra;
    logic [CHW-1:0] wr_ch;
    logic [AW-1:0]  wr_addr, rd_addr;
    logic [CW-1:0]  drop_base;

    assign full = (frames == CNTW'(DEPTH));

    // A sample arriving with frm_start is channel 0 of the new frame.
    always_comb begin
        wr_en = 1'b0;
        wr_ch = ch_cnt;
        if (in_valid) begin
            if (frm_start) begin
                wr_en = !full;
                wr_ch = '0;
            end else begin
                wr_en = (wr_state == W_FILL);
            end
        end
    end

    assign commit    = wr_en && (wr_ch == CHW'(NCH - 1));
    assign drop      = frm_start && full;
    assign set_short = frm_start && (wr_state == W_FILL) && (ch_cnt != '0);
    assign set_extra = in_valid && !frm_start && (wr_state == W_DONE);
    assign pop       = (rd_state == R_PRESENT) && rd_ready && rd_last;
    // A drop on the clearing edge counts against the cleared value.
    assign drop_base = clr_err ? '0 : drop_cnt;

    assign wr_addr = AW'(wr_frame) * AW'(NCH) + AW'(wr_ch);
    assign rd_addr = AW'(rd_frame) * AW'(NCH) + AW'(rd_idx);

    // Frame RAM: no reset so it maps onto block RAM. A write slot is never the
    // slot being read: accepted frames only start while frames < DEPTH.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= in_data;
        if (rd_state == R_FETCH)
            mem_q <= mem[rd_addr];
    end

    // Write FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state <= W_IDLE;
            ch_cnt   <= '0;
            wr_frame <= '0;
        end else begin
            if (frm_start)
                wr_state <= full ? W_DROP : (commit ? W_DONE : W_FILL);
            else if (commit)
                wr_state <= W_DONE;

            if (commit) begin
                ch_cnt   <= '0;
                wr_frame <= wr_frame + FW'(1);
            end else if (wr_en) begin
                ch_cnt <= wr_ch + CHW'(1);
            end else if (frm_start) begin
                ch_cnt <= '0;
            end
        end
    end

    // Shared frame count, status and watermark
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames    <= '0;
            irq       <= 1'b0;
            drop_cnt  <= '0;
            err_short <= 1'b0;
            err_extra <= 1'b0;
        end else begin
            case ({commit, pop})
                2'b10:   frames <= frames + CNTW'(1);
                2'b01:   frames <= frames - CNTW'(1);
                default: frames <= frames;
            endcase
            irq <= (frames >= wm_level);
            if (drop)
                drop_cnt <= (&drop_base) ? drop_base : drop_base + CW'(1);
            else
                drop_cnt <= drop_base;
            err_short <= (err_short && !clr_err) || set_short;
            err_extra <= (err_extra && !clr_err) || set_extra;
        end
    end

    // Read FSM: one FETCH cycle per word for the synchronous RAM read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state <= R_IDLE;
            rd_idx   <= '0;
            rd_frame <= '0;
            rd_valid <= 1'b0;
            rd_ch    <= '0;
            rd_last  <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (rd_req && (frames != '0)) begin
                        rd_state <= R_FETCH;
                        rd_idx   <= '0;
                    end
                end
                R_FETCH: begin
                    rd_state <= R_PRESENT;
                    rd_valid <= 1'b1;
                    rd_ch    <= rd_idx;
                    rd_last  <= (rd_idx == CHW'(NCH - 1));
                end
                R_PRESENT: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        if (rd_last) begin
                            rd_frame <= rd_frame + FW'(1);
                            rd_state <= R_IDLE;
                        end else begin
                            rd_idx   <= rd_idx + CHW'(1);
                            rd_state <= R_FETCH;
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // RAM output register has no reset; gate it so rd_data reads 0 when idle.
    assign rd_data = rd_valid ? mem_q : '0;

endmodule

// File: tb/tb_ecg_frame_fifo.sv
// Testbench for ecg_frame_fifo (NCH=8, DEPTH=4, CW=8).
// Stimulus pushes expected output words into exp_q when a read is requested;
// an independent monitor pops and compares on every rd_valid && rd_ready and
// checks that a stalled word stays stable. Status outputs are checked inline.
module tb_ecg_frame_fifo;
    localparam int NCH = 8, SW = 24, DEPTH = 4, CW = 8;

    logic          clk = 1'b0, reset = 1'b1;
    logic          frm_start = 1'b0, in_valid = 1'b0, rd_req = 1'b0, clr_err = 1'b0;
    logic [SW-1:0] in_data = '0;
    logic [2:0]    wm_level = 3'd1;
    logic          rd_ready, rd_valid, rd_last, irq, err_short, err_extra;
    logic [SW-1:0] rd_data;
    logic [2:0]    rd_ch, frames;
    logic [CW-1:0] drop_cnt;
    logic          bp_mode = 1'b0, bp_rand = 1'b0, rd_ready_fix = 1'b1;

    typedef struct packed {
        logic [SW-1:0] d;
        logic [2:0]    ch;
        logic          last;
    } word_t;

    word_t         exp_q[$];
    logic [SW-1:0] mdl_q[$];   // bases of frames the buffer should hold
    int            n_cmp = 0, n_err = 0;

    assign rd_ready = bp_mode ? bp_rand : rd_ready_fix;

    ecg_frame_fifo #(.NCH(NCH), .SW(SW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .frm_start(frm_start), .in_valid(in_valid),
        .in_data(in_data), .rd_req(rd_req), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_ch(rd_ch), .rd_last(rd_last), .wm_level(wm_level),
        .frames(frames), .irq(irq), .drop_cnt(drop_cnt), .err_short(err_short),
        .err_extra(err_extra), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        bp_rand = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    // Monitor
    logic  hold = 1'b0;
    word_t hd;
    always @(negedge clk) begin
        word_t e;
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                n_cmp++;
                if (!rd_valid || rd_data !== hd.d || rd_ch !== hd.ch || rd_last !== hd.last) begin
                    n_err++;
                    $display("FAIL hold_stable: got v=%b d=%h ch=%0d l=%b want v=1 d=%h ch=%0d l=%b",
                             rd_valid, rd_data, rd_ch, rd_last, hd.d, hd.ch, hd.last);
                end
            end
            if (rd_valid && rd_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word: got d=%h ch=%0d, want none", rd_data, rd_ch);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e.d || rd_ch !== e.ch || rd_last !== e.last) begin
                        n_err++;
                        $display("FAIL word: got d=%h ch=%0d l=%b want d=%h ch=%0d l=%b",
                                 rd_data, rd_ch, rd_last, e.d, e.ch, e.last);
                    end
                end
            end
            hold  = rd_valid && !rd_ready;
            hd.d  = rd_data;
            hd.ch = rd_ch;
            hd.last = rd_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [SW-1:0] base);
        word_t w;
        for (int i = 0; i < NCH; i++) begin
            w.d    = base + SW'(i);
            w.ch   = 3'(i);
            w.last = (i == NCH - 1);
            exp_q.push_back(w);
        end
    endtask

    // frm_start then n samples base+0.., optionally sample 0 with frm_start.
    task automatic write_frame(input logic [SW-1:0] base, input int n, input bit same);
        bit acc;
        acc = (mdl_q.size() < DEPTH);
        frm_start = 1'b1;
        if (same) begin
            in_valid = 1'b1;
            in_data  = base;
        end
        tick();
        frm_start = 1'b0;
        for (int i = (same ? 1 : 0); i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + SW'(i);
            tick();
        end
        in_valid = 1'b0;
        if (acc && n >= NCH)
            mdl_q.push_back(base);
    endtask

    task automatic read_frame();
        int cnt;
        push_exp(mdl_q.pop_front());
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("lat_fetch_valid", rd_valid, 0);
        tick();
        chk("lat_present_valid", rd_valid, 1);
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 400) begin
            tick();
            cnt++;
        end
        chk("read_words_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int cnt;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_frames", frames, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_irq", irq, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_errs", {err_short, err_extra}, 0);
        reset = 1'b0;
        tick();

        // Samples before the first frm_start are ignored silently
        in_valid = 1'b1;
        in_data  = 24'h000055;
        tick();
        tick();
        in_valid = 1'b0;
        chk("pre_start_frames", frames, 0);
        chk("pre_start_extra", err_extra, 0);

        // 1: single frame 1..8, irq follows with one cycle lag
        write_frame(24'h000001, 8, 0);
        chk("t1_frames_commit", frames, 1);
        chk("t1_irq_lag", irq, 0);
        tick();
        chk("t1_irq_set", irq, 1);
        read_frame();
        chk("t1_frames_pop", frames, 0);
        chk("t1_irq_before_clear", irq, 1);
        tick();
        chk("t1_irq_clear", irq, 0);

        // 2: six frames into DEPTH=4 -> two drops
        for (int k = 1; k <= 6; k++)
            write_frame(SW'(k * 256), 8, 0);
        chk("t2_frames_full", frames, 4);
        chk("t2_drop_cnt", drop_cnt, 2);
        chk("t2_irq", irq, 1);
        chk("t2_no_errs", {err_short, err_extra}, 0);
        wm_level = 3'd4;
        tick();
        chk("t2_irq_wm_eq", irq, 1);
        wm_level = 3'd5;
        tick();
        chk("t2_irq_wm_above", irq, 0);
        wm_level = 3'd1;
        for (int k = 0; k < 4; k++)
            read_frame();
        chk("t2_frames_empty", frames, 0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        chk("t2_req_empty_ignored", rd_valid, 0);
        wm_level = 3'd0;
        tick();
        chk("t2_irq_wm0", irq, 1);
        wm_level = 3'd1;
        tick();
        chk("t2_irq_wm1", irq, 0);

        // 3: short frame, then a good one, then an extra sample
        write_frame(24'h0AA000, 3, 0);
        write_frame(24'h0BB000, 8, 0);
        chk("t3_err_short", err_short, 1);
        chk("t3_frames", frames, 1);
        chk("t3_no_extra_yet", err_extra, 0);
        in_valid = 1'b1;
        in_data  = 24'h000BAD;
        tick();
        in_valid = 1'b0;
        chk("t3_err_extra", err_extra, 1);
        chk("t3_frames_after_extra", frames, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_clr_errs", {err_short, err_extra}, 0);
        chk("t3_clr_drop", drop_cnt, 0);
        read_frame();

        // 4: random backpressure, including a frame whose sample 0 rides on frm_start
        bp_mode = 1'b1;
        write_frame(24'h0C0000, 8, 1);
        write_frame(24'h0C1000, 8, 0);
        write_frame(24'h0C2000, 8, 1);
        chk("t4_frames", frames, 3);
        for (int k = 0; k < 3; k++)
            read_frame();
        bp_mode = 1'b0;
        rd_ready_fix = 1'b1;

        // 4b: commit and last-word pop on the same edge
        write_frame(24'h0A0A00, 8, 1);
        write_frame(24'h0B0B00, 7, 0);
        push_exp(mdl_q.pop_front());
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        cnt = 0;
        while (!(rd_valid && rd_last) && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("t4b_last_seen", rd_valid && rd_last, 1);
        chk("t4b_frames_before", frames, 1);
        in_valid = 1'b1;
        in_data  = 24'h0B0B07;
        tick();
        in_valid = 1'b0;
        mdl_q.push_back(24'h0B0B00);
        chk("t4b_frames_same_edge", frames, 1);
        chk("t4b_words_left", exp_q.size(), 0);
        read_frame();

        // 5: pointer wrap with interleaved reads
        for (int k = 0; k < 8; k++) begin
            write_frame(SW'(24'h100000 + k * 32), 8, 0);
            write_frame(SW'(24'h100010 + k * 32), 8, 0);
            read_frame();
            read_frame();
        end
        chk("t5_frames_wrap", frames, 0);

        // 5b: drop counter saturation and clear-vs-drop
        for (int k = 0; k < 4; k++)
            write_frame(SW'(24'h200000 + k * 16), 8, 0);
        frm_start = 1'b1;
        repeat (254) tick();
        chk("t5_drop_254", drop_cnt, 254);
        tick();
        chk("t5_drop_255", drop_cnt, 255);
        repeat (5) tick();
        chk("t5_drop_sat", drop_cnt, 255);
        clr_err = 1'b1;
        tick();
        clr_err   = 1'b0;
        frm_start = 1'b0;
        chk("t5_clr_with_drop", drop_cnt, 1);
        for (int k = 0; k < 4; k++)
            read_frame();
        chk("t5_frames_drained", frames, 0);

        // 6: reset in the middle of a frame read
        write_frame(24'h300000, 8, 0);
        push_exp(mdl_q.pop_front());
        rd_ready_fix = 1'b0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        rd_ready_fix = 1'b1;
        repeat (3) tick();
        rd_ready_fix = 1'b0;
        tick();
        chk("t6_present_before_rst", rd_valid, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_rd_valid", rd_valid, 0);
        chk("t6_rst_frames", frames, 0);
        chk("t6_rst_irq", irq, 0);
        exp_q.delete();
        mdl_q.delete();
        tick();
        reset = 1'b0;
        rd_ready_fix = 1'b1;
        tick();
        write_frame(24'h400000, 8, 0);
        chk("t6_frames_after", frames, 1);
        read_frame();
        chk("t6_frames_end", frames, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
